// File: rtl/data_mem_arbiter_pkg.sv
// Shared types for the data_mem arbiter: the data-memory word and byte-select
// types, the arbiter FSM state encoding and the muxed memory request bundle.
package data_mem_arbiter_pkg;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  byte_sel_t;

  typedef enum logic [1:0] {
    ARB_CORE_PRI  = 2'd0,
    ARB_DBG_FORCE = 2'd1,
    ARB_DBG_LOCK  = 2'd2
  } arb_state_t;

  typedef struct packed {
    byte_sel_t wr_sel;
    word_t     addr;
    word_t     wr_data;
  } mem_req_t;

  // An all-zero byte select marks a read access.
  function automatic logic is_read(input byte_sel_t sel);
    return (sel == '0);
  endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating wait counter for the debug requester.
//   clk         : system clock
//   rst         : synchronous active-high reset
//   inc_i       : debug is requesting but was not granted this cycle
//   clr_i       : debug was granted or is not requesting
//   cnt_o       : current wait count (saturates at LIMIT)
//   limit_hit_o : this cycle's increment reaches LIMIT
module arb_starve_counter #(
  parameter int unsigned LIMIT = 8,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic         limit_hit_o
);

  localparam logic [W:0] LimitExt = (W+1)'(LIMIT);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W:0]   cnt_inc;

  // One extra bit so the compare against LIMIT cannot wrap.
  assign cnt_inc     = {1'b0, cnt_q} + {{W{1'b0}}, 1'b1};
  assign limit_hit_o = inc_i && !clr_i && (cnt_inc == LimitExt);
  assign cnt_o       = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_inc <= LimitExt)) begin
      cnt_d = cnt_inc[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates the single-port data_mem between the core load/store path and the
// debug/loader path. Core has fixed priority; a starvation counter forces a
// debug grant after STARVE_LIMIT waiting cycles, and dbg_lock holds exclusive
// debug ownership for bursts. Read data is registered per requester.
//   clk, rst                     : clock, synchronous active-high reset
//   core_req/wr_sel/addr/wr_data : core access request (wr_sel == 0 is a read)
//   core_gnt                     : combinational grant for the current cycle
//   core_rd_data/rd_valid        : registered read return, valid for one cycle
//   dbg_*                        : same set for the debug port, plus dbg_lock
//   mem_wr_sel/addr/wr_data      : muxed request to data_mem
//   mem_rd_data                  : combinational read data from data_mem
//
// state          | meaning
// ARB_CORE_PRI   | core wins when requesting, otherwise debug
// ARB_DBG_FORCE  | debug waited STARVE_LIMIT cycles, debug granted over core
// ARB_DBG_LOCK   | debug owns the memory until dbg_lock drops
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned CNT_W        = 8
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      core_req,
  input  byte_sel_t core_wr_sel,
  input  word_t     core_addr,
  input  word_t     core_wr_data,
  output logic      core_gnt,
  output word_t     core_rd_data,
  output logic      core_rd_valid,
  input  logic      dbg_req,
  input  byte_sel_t dbg_wr_sel,
  input  word_t     dbg_addr,
  input  word_t     dbg_wr_data,
  input  logic      dbg_lock,
  output logic      dbg_gnt,
  output word_t     dbg_rd_data,
  output logic      dbg_rd_valid,
  output byte_sel_t mem_wr_sel,
  output word_t     mem_addr,
  output word_t     mem_wr_data,
  input  word_t     mem_rd_data
);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] starve_cnt;
  logic             starve_hit;
  mem_req_t         core_port, dbg_port, mem_sel;

  word_t core_rd_data_q, dbg_rd_data_q;
  logic  core_rd_valid_q, dbg_rd_valid_q;

  arb_starve_counter #(
    .LIMIT (STARVE_LIMIT),
    .W     (CNT_W)
  ) u_starve (
    .clk         (clk),
    .rst         (rst),
    .inc_i       (dbg_req && !dbg_gnt),
    .clr_i       (dbg_gnt || !dbg_req),
    .cnt_o       (starve_cnt),
    .limit_hit_o (starve_hit)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ARB_CORE_PRI;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_CORE_PRI: begin
        if (dbg_gnt && dbg_lock) state_d = ARB_DBG_LOCK;
        else if (starve_hit)     state_d = ARB_DBG_FORCE;
      end
      ARB_DBG_FORCE: begin
        state_d = (dbg_gnt && dbg_lock) ? ARB_DBG_LOCK : ARB_CORE_PRI;
      end
      ARB_DBG_LOCK: begin
        if (!dbg_lock) state_d = ARB_CORE_PRI;
      end
      default: state_d = ARB_CORE_PRI;
    endcase
  end

  // Grant outputs; no grant while rst is high so nothing is written in reset.
  always_comb begin
    core_gnt = 1'b0;
    dbg_gnt  = 1'b0;
    if (!rst) begin
      case (state_q)
        ARB_CORE_PRI: begin
          core_gnt = core_req;
          dbg_gnt  = dbg_req && !core_req;
        end
        ARB_DBG_FORCE: begin
          // If debug withdrew while being forced, let the core use the slot.
          dbg_gnt  = dbg_req;
          core_gnt = core_req && !dbg_req;
        end
        ARB_DBG_LOCK: begin
          dbg_gnt = dbg_req;
        end
        default: ;
      endcase
    end
  end

  assign core_port = '{wr_sel: core_wr_sel, addr: core_addr, wr_data: core_wr_data};
  assign dbg_port  = '{wr_sel: dbg_wr_sel,  addr: dbg_addr,  wr_data: dbg_wr_data};

  // Idle memory cycles present the core address with writes disabled.
  always_comb begin
    mem_sel        = core_port;
    mem_sel.wr_sel = '0;
    if (dbg_gnt)       mem_sel = dbg_port;
    else if (core_gnt) mem_sel = core_port;
  end

  assign mem_wr_sel  = mem_sel.wr_sel;
  assign mem_addr    = mem_sel.addr;
  assign mem_wr_data = mem_sel.wr_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      core_rd_data_q  <= '0;
      core_rd_valid_q <= 1'b0;
      dbg_rd_data_q   <= '0;
      dbg_rd_valid_q  <= 1'b0;
    end else begin
      core_rd_valid_q <= core_gnt && is_read(core_wr_sel);
      dbg_rd_valid_q  <= dbg_gnt && is_read(dbg_wr_sel);
      if (core_gnt && is_read(core_wr_sel)) core_rd_data_q <= mem_rd_data;
      if (dbg_gnt && is_read(dbg_wr_sel))   dbg_rd_data_q  <= mem_rd_data;
    end
  end

  assign core_rd_data  = core_rd_data_q;
  assign core_rd_valid = core_rd_valid_q;
  assign dbg_rd_data   = dbg_rd_data_q;
  assign dbg_rd_valid  = dbg_rd_valid_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a small byte-writable data_mem model.
module tb_data_mem_arbiter;
  import data_mem_arbiter_pkg::*;

  localparam int unsigned LIMIT = 4;

  logic      clk = 1'b0;
  logic      rst;
  logic      core_req, core_gnt, core_rd_valid;
  byte_sel_t core_wr_sel;
  word_t     core_addr, core_wr_data, core_rd_data;
  logic      dbg_req, dbg_lock, dbg_gnt, dbg_rd_valid;
  byte_sel_t dbg_wr_sel;
  word_t     dbg_addr, dbg_wr_data, dbg_rd_data;
  byte_sel_t mem_wr_sel;
  word_t     mem_addr, mem_wr_data, mem_rd_data;

  logic [31:0] mem [0:255];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(
    .STARVE_LIMIT (LIMIT),
    .CNT_W        (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .core_req      (core_req),
    .core_wr_sel   (core_wr_sel),
    .core_addr     (core_addr),
    .core_wr_data  (core_wr_data),
    .core_gnt      (core_gnt),
    .core_rd_data  (core_rd_data),
    .core_rd_valid (core_rd_valid),
    .dbg_req       (dbg_req),
    .dbg_wr_sel    (dbg_wr_sel),
    .dbg_addr      (dbg_addr),
    .dbg_wr_data   (dbg_wr_data),
    .dbg_lock      (dbg_lock),
    .dbg_gnt       (dbg_gnt),
    .dbg_rd_data   (dbg_rd_data),
    .dbg_rd_valid  (dbg_rd_valid),
    .mem_wr_sel    (mem_wr_sel),
    .mem_addr      (mem_addr),
    .mem_wr_data   (mem_wr_data),
    .mem_rd_data   (mem_rd_data)
  );

  assign mem_rd_data = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_wr_sel[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wr_data[8*b +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic core_drive(input logic req, input logic [3:0] sel,
                            input logic [31:0] addr, input logic [31:0] data);
    core_req = req; core_wr_sel = sel; core_addr = addr; core_wr_data = data;
  endtask

  task automatic dbg_drive(input logic req, input logic [3:0] sel,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic lock);
    dbg_req = req; dbg_wr_sel = sel; dbg_addr = addr; dbg_wr_data = data;
    dbg_lock = lock;
  endtask

  initial begin
    // Reset with a core write pending: nothing may reach the memory.
    rst = 1'b1;
    core_drive(1'b1, 4'hF, 32'h10, 32'hFFFF_FFFF);
    dbg_drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    sample();
    check("rst_mem_wr_sel", 32'(mem_wr_sel), 32'h0);
    check("rst_core_gnt", 32'(core_gnt), 32'h0);
    check("rst_core_rd_valid", 32'(core_rd_valid), 32'h0);
    check("rst_dbg_rd_valid", 32'(dbg_rd_valid), 32'h0);
    check("rst_core_rd_data", core_rd_data, 32'h0);
    tick();
    rst = 1'b0;
    core_drive(1'b0, 4'h0, 32'h0, 32'h0);
    sample();
    check("post_rst_state", 32'(dut.state_q), 32'(ARB_CORE_PRI));
    check("post_rst_cnt", 32'(dut.starve_cnt), 32'h0);
    check("post_rst_core_gnt", 32'(core_gnt), 32'h0);
    tick();

    // Preload through the core port.
    core_drive(1'b1, 4'hF, 32'h10, 32'h1234_5678);
    sample();
    check("pre_core_gnt", 32'(core_gnt), 32'h1);
    check("pre_mem_wr_sel", 32'(mem_wr_sel), 32'hF);
    check("pre_mem_addr", mem_addr, 32'h10);
    tick();
    core_drive(1'b1, 4'hF, 32'h40, 32'h1122_3344);
    sample();
    check("wr_no_rd_valid", 32'(core_rd_valid), 32'h0);
    tick();

    // Simultaneous requests: core read wins, debug write follows.
    core_drive(1'b1, 4'h0, 32'h10, 32'h0);
    dbg_drive(1'b1, 4'hF, 32'h20, 32'hCAFE_F00D, 1'b0);
    sample();
    check("sim_core_gnt", 32'(core_gnt), 32'h1);
    check("sim_dbg_gnt", 32'(dbg_gnt), 32'h0);
    check("sim_mem_addr", mem_addr, 32'h10);
    check("sim_mem_wr_sel", 32'(mem_wr_sel), 32'h0);
    tick();
    core_drive(1'b0, 4'h0, 32'h0, 32'h0);
    sample();
    check("sim_dbg_gnt2", 32'(dbg_gnt), 32'h1);
    check("sim_core_rd_valid", 32'(core_rd_valid), 32'h1);
    check("sim_core_rd_data", core_rd_data, 32'h1234_5678);
    tick();
    dbg_drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    sample();
    check("sim_core_rd_valid_pulse", 32'(core_rd_valid), 32'h0);
    check("sim_dbg_wr_no_valid", 32'(dbg_rd_valid), 32'h0);
    tick();

    // Starvation: core holds its request, debug is forced in at cycle 4.
    core_drive(1'b1, 4'h0, 32'h10, 32'h0);
    dbg_drive(1'b1, 4'h0, 32'h20, 32'h0, 1'b0);
    for (int c = 0; c < 6; c++) begin
      sample();
      check($sformatf("starve_core_gnt_c%0d", c), 32'(core_gnt), (c == 4) ? 32'h0 : 32'h1);
      check($sformatf("starve_dbg_gnt_c%0d", c), 32'(dbg_gnt), (c == 4) ? 32'h1 : 32'h0);
      if (c == 3) check("starve_cnt_c3", 32'(dut.starve_cnt), 32'h3);
      if (c == 4) check("starve_state_c4", 32'(dut.state_q), 32'(ARB_DBG_FORCE));
      if (c == 5) begin
        check("starve_dbg_rd_valid", 32'(dbg_rd_valid), 32'h1);
        check("starve_dbg_rd_data", dbg_rd_data, 32'hCAFE_F00D);
        check("starve_core_rd_valid", 32'(core_rd_valid), 32'h0);
      end
      tick();
    end
    core_drive(1'b0, 4'h0, 32'h0, 32'h0);
    dbg_drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);

    // Locked debug burst to 0x100 / 0x104 while the core keeps asking.
    dbg_drive(1'b1, 4'hF, 32'h100, 32'hA5A5_A5A5, 1'b1);
    sample();
    check("lock_dbg_gnt0", 32'(dbg_gnt), 32'h1);
    check("lock_mem_addr0", mem_addr, 32'h100);
    tick();
    core_drive(1'b1, 4'h0, 32'h10, 32'h0);
    dbg_drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    sample();
    check("lock_state", 32'(dut.state_q), 32'(ARB_DBG_LOCK));
    check("lock_core_gnt1", 32'(core_gnt), 32'h0);
    check("lock_idle_wr_sel", 32'(mem_wr_sel), 32'h0);
    tick();
    dbg_drive(1'b1, 4'hF, 32'h104, 32'hA5A5_A5A5, 1'b0);
    sample();
    check("lock_dbg_gnt2", 32'(dbg_gnt), 32'h1);
    check("lock_core_gnt2", 32'(core_gnt), 32'h0);
    check("lock_mem_addr2", mem_addr, 32'h104);
    tick();
    dbg_drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    sample();
    check("unlock_core_gnt", 32'(core_gnt), 32'h1);
    tick();
    sample();
    check("lock_no_req_state", 32'(dut.state_q), 32'(ARB_CORE_PRI));
    check("lock_no_req_core_gnt", 32'(core_gnt), 32'h1);
    check("unlock_core_rd_data", core_rd_data, 32'h1234_5678);
    tick();
    core_drive(1'b0, 4'h0, 32'h0, 32'h0);
    dbg_drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);

    // Byte write into 0x40, then read back.
    dbg_drive(1'b1, 4'b0010, 32'h40, 32'h0000_BB00, 1'b0);
    sample();
    check("byte_mem_wr_sel", 32'(mem_wr_sel), 32'h2);
    tick();
    dbg_drive(1'b1, 4'h0, 32'h40, 32'h0, 1'b0);
    sample();
    check("byte_rd_gnt", 32'(dbg_gnt), 32'h1);
    tick();
    dbg_drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    sample();
    check("byte_rd_valid", 32'(dbg_rd_valid), 32'h1);
    check("byte_rd_data", dbg_rd_data, 32'h1122_BB44);
    tick();
    dbg_drive(1'b1, 4'h0, 32'h104, 32'h0, 1'b0);
    sample();
    check("byte_rd_valid_pulse", 32'(dbg_rd_valid), 32'h0);
    check("byte_rd_data_hold", dbg_rd_data, 32'h1122_BB44);
    tick();
    dbg_drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    sample();
    check("burst_rd_data", dbg_rd_data, 32'hA5A5_A5A5);
    tick();

    // Reset while locked, with a core write presented during reset.
    dbg_drive(1'b1, 4'hF, 32'h300, 32'h77, 1'b1);
    sample();
    check("rlock_dbg_gnt", 32'(dbg_gnt), 32'h1);
    tick();
    rst = 1'b1;
    core_drive(1'b1, 4'hF, 32'h10, 32'hFFFF_FFFF);
    dbg_drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    sample();
    check("rlock_mem_wr_sel", 32'(mem_wr_sel), 32'h0);
    check("rlock_dbg_gnt_rst", 32'(dbg_gnt), 32'h0);
    tick();
    rst = 1'b0;
    core_drive(1'b1, 4'h0, 32'h10, 32'h0);
    sample();
    check("rlock_state", 32'(dut.state_q), 32'(ARB_CORE_PRI));
    check("rlock_core_gnt", 32'(core_gnt), 32'h1);
    check("rlock_cnt", 32'(dut.starve_cnt), 32'h0);
    tick();
    core_drive(1'b0, 4'h0, 32'h0, 32'h0);
    dbg_drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    sample();
    check("rlock_core_rd_valid", 32'(core_rd_valid), 32'h1);
    check("rlock_core_rd_data", core_rd_data, 32'h1234_5678);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
